apb_mem_master: RTL and testbench

Single-outstanding AMBA APB requester that turns a simple valid/ready command stream into APB transfers against the 128x32 APB memory slave, and returns read data and error status on a valid/ready response stream. It sits between on-chip initiators (test sequencers, config engines) and the APB memory slave. It drives the standard SETUP/ACCESS phase sequence, honours slave wait states and PSLVERR, and optionally aborts hung transfers with a timeout.

---
 rtl/apb_mem_master_if.sv | 53 +++++
 rtl/apb_mem_master.sv | 186 ++++++++++++++++++
 tb/tb_apb_mem_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_mem_master_if.sv
// ---------------------------------------------------------------------------
// apb_mem_master_if: command, response and APB bundle for apb_mem_master.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface apb_mem_master_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);

  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_write;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic [DATA_WIDTH-1:0] i_cmd_wdata;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;
  logic                  o_rsp_err;
  logic                  o_rsp_timeout;

  logic                  o_psel;
  logic                  o_penable;
  logic                  o_pwrite;
  logic [ADDR_WIDTH-1:0] o_paddr;
  logic [DATA_WIDTH-1:0] o_pwdata;
  logic [DATA_WIDTH-1:0] i_prdata;
  logic                  i_pready;
  logic                  i_pslverr;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata,
    input  i_rsp_ready,
    input  i_prdata, i_pready, i_pslverr,
    output o_cmd_ready,
    output o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata,
    output i_rsp_ready,
    output i_prdata, i_pready, i_pslverr,
    input  o_cmd_ready,
    input  o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
  );

endinterface

`default_nettype wire

// File: rtl/apb_mem_master.sv
// ---------------------------------------------------------------------------
// apb_mem_master: single-outstanding APB requester between cmd/rsp streams.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases hung on PREADY. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_mem_master #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  apb_mem_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                  cmd_ready_q,   cmd_ready_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  pwrite_q,      pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;

  // Counter holds the number of PREADY-low cycles already spent in ACCESS,
  // so this one is the TIMEOUT_CYCLES-th when it equals TIMEOUT_CYCLES-1.
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 1);
`endif

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.i_cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          pwrite_d    = bus.i_cmd_write;
          paddr_d     = bus.i_cmd_addr;
          pwdata_d    = bus.i_cmd_wdata;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          state_d     = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end

      ACCESS: begin
        // A ready slave always wins over an expiring timeout.
        if (bus.i_pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.i_prdata;
          rsp_err_d     = bus.i_pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign bus.o_cmd_ready   = cmd_ready_q;
  assign bus.o_psel        = psel_q;
  assign bus.o_penable     = penable_q;
  assign bus.o_pwrite      = pwrite_q;
  assign bus.o_paddr       = paddr_q;
  assign bus.o_pwdata      = pwdata_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_rdata   = rsp_rdata_q;
  assign bus.o_rsp_err     = rsp_err_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_master.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_master: directed scoreboard bench with a 128x32 APB memory slave.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_mem_master;

  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_mem_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_mem_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Memory slave: lower half read-only (PSLVERR on write), reset contents = address.
  logic [31:0] mem [128];
  int          wait_target = 0;
  int          wait_cnt    = 0;
  logic        stuck       = 1'b0;
  logic        access;

  assign access        = bus.o_psel && bus.o_penable;
  assign bus.i_pready  = access && !stuck && (wait_cnt >= wait_target);
  assign bus.i_prdata  = bus.i_pready ? mem[bus.o_paddr] : 32'hBADBAD00;
  assign bus.i_pslverr = bus.i_pready ? (bus.o_pwrite && (bus.o_paddr < 7'h40)) : 1'b1;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] <= 32'(i);
  end

  always @(posedge clk) begin
    if (access && !bus.i_pready) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
    if (bus.i_pready && bus.o_pwrite && !bus.i_pslverr) mem[bus.o_paddr] <= bus.o_pwdata;
  end

  // Monitor: latency, APB phase stability and scoreboard pops.
  int          cyc        = 0;
  int          accept_cyc = 0;
  logic        prev_rsp_valid = 1'b0;
  logic        prev_psel      = 1'b0;
  logic [6:0]  lat_addr   = '0;
  logic        lat_write  = 1'b0;
  logic [31:0] lat_wdata  = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_rsp_valid <= 1'b0;
      prev_psel      <= 1'b0;
    end else begin
      if (bus.i_cmd_valid && bus.o_cmd_ready) accept_cyc <= cyc;
      if (bus.o_psel && !bus.o_penable) begin
        check("psel_gap_before_setup", prev_psel, 0);
        lat_addr  <= bus.o_paddr;
        lat_write <= bus.o_pwrite;
        lat_wdata <= bus.o_pwdata;
      end
      if (bus.o_psel && bus.o_penable) begin
        check("access_paddr_stable",  bus.o_paddr,  lat_addr);
        check("access_pwrite_stable", bus.o_pwrite, lat_write);
        check("access_pwdata_stable", bus.o_pwdata, lat_wdata);
      end
      if (bus.o_rsp_valid && !prev_rsp_valid) begin
        check("rsp_expected", sb.size() > 0, 1);
        if (sb.size() > 0) check("rsp_latency", cyc - accept_cyc, sb[0].lat);
      end
      if (bus.o_rsp_valid && bus.i_rsp_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata",   bus.o_rsp_rdata,   e.rdata);
        check("rsp_err",     bus.o_rsp_err,     e.err);
        check("rsp_timeout", bus.o_rsp_timeout, e.tmo);
      end
      prev_rsp_valid <= bus.o_rsp_valid;
      prev_psel      <= bus.o_psel;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge (DUT now in SETUP).
  task automatic send(input logic w, input logic [6:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input logic et,
                      input int lat, input bit push);
    exp_t e;
    int   n;
    e.rdata = er; e.err = ee; e.tmo = et; e.lat = lat;
    if (push) sb.push_back(e);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = w;
    bus.i_cmd_addr  = a;
    bus.i_cmd_wdata = d;
    n = 0;
    while (!bus.o_cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_accept_bound", n < 50, 1);
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.o_rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check("rsp_valid_bound", n < 200, 1);
  endtask

  task automatic consume();
    wait_valid();
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
    check("idle_after_rsp_cmd_ready", bus.o_cmd_ready, 1);
    check("idle_after_rsp_valid",     bus.o_rsp_valid, 0);
  endtask

  task automatic reset_during_access();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_psel",      bus.o_psel,      0);
    check("rst_async_penable",   bus.o_penable,   0);
    check("rst_async_rsp_valid", bus.o_rsp_valid, 0);
    check("rst_async_cmd_ready", bus.o_cmd_ready, 0);
    sb.delete();
    stuck       = 1'b0;
    wait_target = 0;
    tick();
    rst = 1'b0;
    check("rst_release_cmd_ready_low", bus.o_cmd_ready, 0);
    tick();
    check("rst_release_cmd_ready_high", bus.o_cmd_ready, 1);
  endtask

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_addr  = '0;
    bus.i_cmd_wdata = '0;
    bus.i_rsp_ready = 1'b0;

    tick();
    tick();
    check("reset_cmd_ready", bus.o_cmd_ready, 0);
    check("reset_psel",      bus.o_psel,      0);
    check("reset_penable",   bus.o_penable,   0);
    check("reset_rsp_valid", bus.o_rsp_valid, 0);
    check("reset_paddr",     bus.o_paddr,     0);
    check("reset_rsp_rdata", bus.o_rsp_rdata, 0);
    rst = 1'b0;
    check("release_cmd_ready_low", bus.o_cmd_ready, 0);
    tick();
    check("release_cmd_ready_high", bus.o_cmd_ready, 1);

    // Zero-wait write then read back
    send(1'b1, 7'h40, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 3, 1'b1);
    check("setup_psel",    bus.o_psel,    1);
    check("setup_penable", bus.o_penable, 0);
    consume();
    send(1'b0, 7'h40, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1'b1);
    consume();

    // Write into the read-only half raises PSLVERR; contents unchanged
    send(1'b1, 7'h10, 32'hAAAA5555, 32'h0, 1'b1, 1'b0, 3, 1'b1);
    consume();
    send(1'b0, 7'h10, 32'h0, 32'h00000010, 1'b0, 1'b0, 3, 1'b1);
    consume();

    // Three wait states
    wait_target = 3;
    send(1'b0, 7'h7F, 32'h0, 32'h0000007F, 1'b0, 1'b0, 6, 1'b1);
    consume();
    wait_target = 0;

    // Back-pressure on the response while a new command waits
    send(1'b0, 7'h40, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1'b1);
    wait_valid();
    send_next_setup();

    // Hung slave
    stuck = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
    send(1'b0, 7'h20, 32'h0, 32'h0, 1'b1, 1'b1, TMO + 2, 1'b1);
    consume();
    stuck = 1'b0;
`else
    send(1'b0, 7'h20, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    repeat (100) tick();
    check("hung_psel_held",    bus.o_psel,      1);
    check("hung_penable_held", bus.o_penable,   1);
    check("hung_no_rsp",       bus.o_rsp_valid, 0);
    reset_during_access();
`endif

    // Reset in the middle of ACCESS, then a clean read
    wait_target = 5;
    send(1'b0, 7'h7F, 32'h0, 32'h0000007F, 1'b0, 1'b0, 8, 1'b1);
    tick();
    check("pre_rst_in_access", bus.o_penable, 1);
    reset_during_access();
    send(1'b0, 7'h40, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1'b1);
    consume();

    tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Holds the pending response 5 cycles with a new write offered, then consumes.
  task automatic send_next_setup();
    exp_t e;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = 1'b1;
    bus.i_cmd_addr  = 7'h41;
    bus.i_cmd_wdata = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_rsp_valid", bus.o_rsp_valid, 1);
      check("hold_rsp_rdata", bus.o_rsp_rdata, 32'hDEADBEEF);
      check("hold_rsp_err",   bus.o_rsp_err,   0);
      check("hold_cmd_ready", bus.o_cmd_ready, 0);
      check("hold_psel",      bus.o_psel,      0);
    end
    e.rdata = 32'h0; e.err = 1'b0; e.tmo = 1'b0; e.lat = 3;
    sb.push_back(e);
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
    check("post_hs_cmd_ready", bus.o_cmd_ready, 1);
    check("post_hs_not_accepted", bus.o_psel, 0);
    tick();
    bus.i_cmd_valid = 1'b0;
    check("next_cmd_setup", bus.o_psel, 1);
    consume();
    send(1'b0, 7'h41, 32'h0, 32'h12345678, 1'b0, 1'b0, 3, 1'b1);
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
